note_key_encoder: RTL and testbench

//  Input-side counterpart of the 7-seg note display: turns raw note switches and octave

---
 rtl/note_key_encoder_pkg.sv | 65 ++++++
 rtl/note_key_encoder_if.sv | 21 ++
 rtl/note_key_encoder_debounce_bit.sv | 42 ++++
 rtl/note_key_encoder.sv | 94 +++++++++
 tb/tb_note_key_encoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/note_key_encoder_pkg.sv
// Shared constants for the note input/display paths: note frequencies, octave
// encoding, the "no key" index and the display mode codes.
package note_pkg;

  localparam logic [31:0] FRE_DO_LOW  = 32'd131;
  localparam logic [31:0] FRE_RE_LOW  = 32'd147;
  localparam logic [31:0] FRE_MI_LOW  = 32'd165;
  localparam logic [31:0] FRE_FA_LOW  = 32'd175;
  localparam logic [31:0] FRE_SO_LOW  = 32'd196;
  localparam logic [31:0] FRE_LA_LOW  = 32'd220;
  localparam logic [31:0] FRE_SI_LOW  = 32'd247;

  localparam logic [31:0] FRE_DO      = 32'd262;
  localparam logic [31:0] FRE_RE      = 32'd294;
  localparam logic [31:0] FRE_MI      = 32'd330;
  localparam logic [31:0] FRE_FA      = 32'd349;
  localparam logic [31:0] FRE_SO      = 32'd392;
  localparam logic [31:0] FRE_LA      = 32'd440;
  localparam logic [31:0] FRE_SI      = 32'd494;

  localparam logic [31:0] FRE_DO_HIGH = 32'd523;
  localparam logic [31:0] FRE_RE_HIGH = 32'd587;
  localparam logic [31:0] FRE_MI_HIGH = 32'd659;
  localparam logic [31:0] FRE_FA_HIGH = 32'd698;
  localparam logic [31:0] FRE_SO_HIGH = 32'd784;
  localparam logic [31:0] FRE_LA_HIGH = 32'd880;
  localparam logic [31:0] FRE_SI_HIGH = 32'd988;

  typedef enum logic [1:0] {
    OCT_LOW  = 2'd0,
    OCT_MID  = 2'd1,
    OCT_HIGH = 2'd2
  } octave_t;

  localparam logic [2:0] NOTE_NONE = 3'd7;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_PLAY  = 2'd1;
  localparam logic [1:0] MODE_LEARN = 2'd2;

  // Unknown index (including NOTE_NONE) maps to 0, which the buzzer treats as silence.
  function automatic logic [31:0] note_fre(input logic [2:0] idx, input octave_t oct);
    logic [31:0] lo, mid, hi, res;
    lo  = '0;
    mid = '0;
    hi  = '0;
    case (idx)
      3'd0: begin lo = FRE_DO_LOW; mid = FRE_DO; hi = FRE_DO_HIGH; end
      3'd1: begin lo = FRE_RE_LOW; mid = FRE_RE; hi = FRE_RE_HIGH; end
      3'd2: begin lo = FRE_MI_LOW; mid = FRE_MI; hi = FRE_MI_HIGH; end
      3'd3: begin lo = FRE_FA_LOW; mid = FRE_FA; hi = FRE_FA_HIGH; end
      3'd4: begin lo = FRE_SO_LOW; mid = FRE_SO; hi = FRE_SO_HIGH; end
      3'd5: begin lo = FRE_LA_LOW; mid = FRE_LA; hi = FRE_LA_HIGH; end
      3'd6: begin lo = FRE_SI_LOW; mid = FRE_SI; hi = FRE_SI_HIGH; end
      default: ;
    endcase
    case (oct)
      OCT_LOW:  res = lo;
      OCT_HIGH: res = hi;
      default:  res = mid;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/note_key_encoder_if.sv
// Board-side inputs and note-code outputs of the note key encoder.
interface note_key_encoder_if;
  logic [6:0]  key_raw;
  logic        oct_up_raw;
  logic        oct_dn_raw;
  logic [31:0] fre;
  logic [2:0]  note_idx;
  logic [1:0]  octave;
  logic        note_valid;
  logic        press_pulse;

  modport master (
    output key_raw, oct_up_raw, oct_dn_raw,
    input  fre, note_idx, octave, note_valid, press_pulse
  );

  modport slave (
    input  key_raw, oct_up_raw, oct_dn_raw,
    output fre, note_idx, octave, note_valid, press_pulse
  );
endinterface

// File: rtl/note_key_encoder_debounce_bit.sv
// One raw board input: two-flop synchroniser followed by a stability counter
// that only lets the debounced level follow after DEBOUNCE_CYCLES steady cycles.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic meta;
  logic synced;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  // Any cycle where the synced input agrees with the debounced level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_key_encoder.sv
// Debounces note keys and octave buttons, picks the lowest pressed note, tracks
// a saturating octave and drives the registered note code for display/buzzer.
import note_pkg::*;

module note_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input logic             clk,
  input logic             rst,
  note_key_encoder_if.slave bus
);

  logic [8:0] raw_vec;
  logic [8:0] level_vec;
  logic [2:0] enc_idx;
  logic [2:0] stage_idx;
  logic       up_prev;
  logic       dn_prev;
  logic       up_rise;
  logic       dn_rise;
  octave_t    oct_state;

  assign raw_vec = {bus.oct_dn_raw, bus.oct_up_raw, bus.key_raw};

  for (genvar i = 0; i < 9; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[i]),
      .level(level_vec[i])
    );
  end

  // Scan from the top so the lowest-index pressed key is the one left standing.
  always_comb begin
    enc_idx = NOTE_NONE;
    for (int k = 6; k >= 0; k--) begin
      if (level_vec[k]) enc_idx = 3'(k);
    end
  end

  assign up_rise = level_vec[7] & ~up_prev;
  assign dn_rise = level_vec[8] & ~dn_prev;

  // Opposing edges in the same cycle cancel; a held button produces only one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oct_state <= OCT_MID;
      up_prev   <= 1'b0;
      dn_prev   <= 1'b0;
      stage_idx <= NOTE_NONE;
    end else begin
      up_prev   <= level_vec[7];
      dn_prev   <= level_vec[8];
      stage_idx <= enc_idx;
      if (up_rise && !dn_rise) begin
        case (oct_state)
          OCT_LOW: oct_state <= OCT_MID;
          OCT_MID: oct_state <= OCT_HIGH;
          default: oct_state <= OCT_HIGH;
        endcase
      end else if (dn_rise && !up_rise) begin
        case (oct_state)
          OCT_HIGH: oct_state <= OCT_MID;
          OCT_MID:  oct_state <= OCT_LOW;
          default:  oct_state <= OCT_LOW;
        endcase
      end
    end
  end

  // press_pulse compares against the index currently on the port, so an octave
  // change with the same key held never re-triggers it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fre         <= '0;
      bus.note_idx    <= NOTE_NONE;
      bus.octave      <= OCT_MID;
      bus.note_valid  <= 1'b0;
      bus.press_pulse <= 1'b0;
    end else begin
      bus.fre         <= note_fre(stage_idx, oct_state);
      bus.note_idx    <= stage_idx;
      bus.octave      <= oct_state;
      bus.note_valid  <= (stage_idx != NOTE_NONE);
      bus.press_pulse <= (stage_idx != NOTE_NONE) && (stage_idx != bus.note_idx);
    end
  end

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder: directed scenarios plus random key/button traffic,
// all compared each cycle against a window-based behavioural model.
module tb_note_key_encoder;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   pulse_count = 0;

  always #5 clk = ~clk;

  note_key_encoder_if bus ();

  note_key_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int fre_tab [0:2][0:6] = '{
    '{131, 147, 165, 175, 196, 220, 247},
    '{262, 294, 330, 349, 392, 440, 494},
    '{523, 587, 659, 698, 784, 880, 988}
  };

  // Model state: a debounced bit flips once the last D synchronised samples all
  // disagree with it; outputs lag the debounced keys by two clock edges.
  logic [8:0] s1, s2, synced, deb, deb_prev;
  logic [8:0] win [$];
  int s_idx, s_oct, m_idx, m_oct, prev_out;
  bit m_pulse;

  function automatic int lowest_key(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i;
    return 7;
  endfunction

  task automatic model_reset();
    s1 = '0; s2 = '0; deb = '0; deb_prev = '0;
    win.delete();
    s_idx = 7; s_oct = 1; m_idx = 7; m_oct = 1; m_pulse = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      bit up_r, dn_r, all_diff;
      prev_out = m_idx;
      m_idx    = s_idx;
      m_oct    = s_oct;
      m_pulse  = (s_idx != 7) && (s_idx != prev_out);
      s_idx    = lowest_key(deb[6:0]);
      up_r = deb[7] && !deb_prev[7];
      dn_r = deb[8] && !deb_prev[8];
      if (up_r && !dn_r && s_oct < 2) s_oct++;
      if (dn_r && !up_r && s_oct > 0) s_oct--;
      deb_prev = deb;
      synced = s2;
      s2 = s1;
      s1 = {bus.oct_dn_raw, bus.oct_up_raw, bus.key_raw};
      win.push_back(synced);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        for (int b = 0; b < 9; b++) begin
          all_diff = 1;
          foreach (win[i]) if (win[i][b] == deb[b]) all_diff = 0;
          if (all_diff) deb[b] = ~deb[b];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checkOutput("model_idx", 32'(bus.note_idx), 32'(m_idx));
      checkOutput("model_oct", 32'(bus.octave), 32'(m_oct));
      checkOutput("model_fre", bus.fre, (m_idx == 7) ? 32'd0 : 32'(fre_tab[m_oct][m_idx]));
      checkOutput("model_valid", 32'(bus.note_valid), 32'(m_idx != 7));
      checkOutput("model_pulse", 32'(bus.press_pulse), 32'(m_pulse));
      if (bus.press_pulse) pulse_count++;
    end
  end

  task automatic applyStimulus(input logic [6:0] keys, input logic up, input logic dn, input int cycles);
    @(negedge clk);
    bus.key_raw    = keys;
    bus.oct_up_raw = up;
    bus.oct_dn_raw = dn;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic checkLiteral(input string tag, input int idx, input int oct, input int fre, input int valid);
    checkOutput({tag, "_idx"}, 32'(bus.note_idx), 32'(idx));
    checkOutput({tag, "_oct"}, 32'(bus.octave), 32'(oct));
    checkOutput({tag, "_fre"}, bus.fre, 32'(fre));
    checkOutput({tag, "_valid"}, 32'(bus.note_valid), 32'(valid));
  endtask

  initial begin
    bus.key_raw = '0;
    bus.oct_up_raw = 1'b0;
    bus.oct_dn_raw = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkLiteral("reset", 7, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(7'b0, 0, 0, 4);

    $display("[TB] latency: press mi");
    pulse_count = 0;
    @(negedge clk);
    bus.key_raw = 7'b0000100;
    repeat (7) @(posedge clk);
    #2;
    checkLiteral("edge6", 7, 1, 0, 0);
    @(posedge clk);
    #2;
    checkLiteral("edge7", 2, 1, 330, 1);
    checkOutput("edge7_pulse", 32'(bus.press_pulse), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("edge8_pulse", 32'(bus.press_pulse), 32'd0);

    $display("[TB] glitch on do");
    pulse_count = 0;
    @(negedge clk);
    bus.key_raw = 7'b0000101;
    repeat (3) @(negedge clk);
    bus.key_raw = 7'b0000100;
    repeat (12) @(posedge clk);
    #2;
    checkLiteral("glitch", 2, 1, 330, 1);
    checkOutput("glitch_pulses", 32'(pulse_count), 32'd0);

    $display("[TB] re+si then release re");
    pulse_count = 0;
    applyStimulus(7'b1000010, 0, 0, 10);
    checkLiteral("re_si", 1, 1, 294, 1);
    applyStimulus(7'b1000000, 0, 0, 10);
    checkLiteral("si", 6, 1, 494, 1);
    checkOutput("re_si_pulses", 32'(pulse_count), 32'd2);

    $display("[TB] octave steps with la held");
    applyStimulus(7'b0100000, 0, 0, 10);
    pulse_count = 0;
    applyStimulus(7'b0100000, 1, 0, 8);
    applyStimulus(7'b0100000, 0, 0, 8);
    checkLiteral("up1", 5, 2, 880, 1);
    for (int n = 0; n < 2; n++) begin
      applyStimulus(7'b0100000, 1, 0, 8);
      applyStimulus(7'b0100000, 0, 0, 8);
    end
    checkLiteral("up3", 5, 2, 880, 1);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(7'b0100000, 0, 1, 8);
      applyStimulus(7'b0100000, 0, 0, 8);
    end
    checkLiteral("dn3", 5, 0, 220, 1);
    applyStimulus(7'b0100000, 1, 0, 8);
    applyStimulus(7'b0100000, 0, 0, 8);
    checkLiteral("up_mid", 5, 1, 440, 1);
    applyStimulus(7'b0100000, 1, 1, 8);
    applyStimulus(7'b0100000, 0, 0, 8);
    checkLiteral("both", 5, 1, 440, 1);
    checkOutput("octave_pulses", 32'(pulse_count), 32'd0);

    $display("[TB] release all");
    applyStimulus(7'b0, 0, 0, 10);
    checkLiteral("release", 7, 1, 0, 0);
    checkOutput("release_pulses", 32'(pulse_count), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(7'b0001000, 1, 0, 8);
    applyStimulus(7'b0001000, 0, 0, 8);
    checkLiteral("pre_rst", 3, 2, 698, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkLiteral("async_rst", 7, 1, 0, 0);
    checkOutput("async_rst_pulse", 32'(bus.press_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checkLiteral("redebounce_wait", 7, 1, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    checkLiteral("redebounced", 3, 1, 349, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 120; n++) begin
      logic [6:0] k;
      logic u, d;
      k = ($urandom_range(0, 3) == 0) ? 7'b0 : 7'($urandom);
      u = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 5) == 0);
      applyStimulus(k, u, d, $urandom_range(1, 12));
    end
    applyStimulus(7'b0, 0, 0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
